// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues single-byte I2C commands and runs them one at a time on the master,
// returning NACK/timeout status and read data through a valid/ready response.
module i2c_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       en,
    output logic [6:0] addr,
    output logic       rw,
    output logic [7:0] data_wr,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_nack,
    input  logic [7:0] m_rdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [15:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic [15:0] timer;
    logic push, pop, active, done, expire;

    assign cmd_ready = count < (AW+1)'(DEPTH);
    assign push = cmd_valid & cmd_ready;

    // m_done outranks the timeout when both land on the same cycle
    always_comb begin
        active = state == LAUNCH || state == WAIT;
        done = active && m_done;
        expire = active && !m_done && timer == 16'(TIMEOUT);
        pop = state == IDLE && count != '0 && !m_busy;
        state_n = state;
        case (state)
            IDLE:    state_n = pop ? LAUNCH : IDLE;
            LAUNCH:  state_n = (done || expire) ? RESP : m_busy ? WAIT : LAUNCH;
            WAIT:    state_n = (done || expire) ? RESP : WAIT;
            default: state_n = rsp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            timer <= '0;
            en <= 1'b0;
            addr <= '0;
            rw <= 1'b0;
            data_wr <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_err <= '0;
        end else begin
            en <= state_n == LAUNCH;
            rsp_valid <= state_n == RESP;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wp <= wp + AW'(1);
            if (pop) begin
                rp <= rp + AW'(1);
                {addr, rw, data_wr} <= mem[rp];
            end
            timer <= pop ? '0 : active ? timer + 16'd1 : timer;
            if (done) begin
                rsp_err <= {1'b0, m_nack};
                rsp_data <= (rw && !m_nack) ? m_rdata : '0;
            end else if (expire) begin
                rsp_err <= 2'b10;
                rsp_data <= '0;
            end
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wp] <= {cmd_addr, cmd_rw, cmd_data};
endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Transaction sequencer that sits directly upstream of the I2C master. It buffers single-byte read/write commands from the host side in a small FIFO and launches them one at a time on the master's `en`/`addr`/`rw`/`data_wr` inputs. It waits for the master's completion or a timeout, then returns a status/data response through a valid/ready handshake. Fully synchronous to the system clock that also feeds the master's clock divider.

## Interface
- `DEPTH`, 4: command FIFO depth in entries; power of two, 2..16.
- `TIMEOUT`, 255: cycles allowed from launch to `m_done` before abort; 1..65535.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  FIFO can accept; high when count < `DEPTH`.
- `cmd_addr`  in  7  target 7-bit slave address.
- `cmd_rw`  in  1  0 = write, 1 = read.
- `cmd_data`  in  8  write byte (ignored for reads).
- `en`  out  1  master start request.
- `addr`  out  7  address to master.
- `rw`  out  1  direction to master.
- `data_wr`  out  8  write byte to master.
- `m_busy`  in  1  master transaction in progress.
- `m_done`  in  1  one-cycle pulse at master STOP.
- `m_nack`  in  1  valid with `m_done`; 1 = address/data NACK.
- `m_rdata`  in  8  valid with `m_done`; read byte.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  host accepts response.
- `rsp_data`  out  8  read byte; 0 for writes and errors.
- `rsp_err`  out  2  00 OK, 01 NACK, 10 timeout.

## Operation
- FIFO: 16-bit entries {addr, rw, data}, write/read pointers of log2(`DEPTH`) bits that wrap modulo `DEPTH`, and a count of log2(`DEPTH`)+1 bits.
  - A push occurs when `cmd_valid & cmd_ready`.
  - A pop occurs on the IDLE to LAUNCH transition.
  - Simultaneous push and pop leaves the count unchanged.
  - `cmd_ready` depends only on the count, so a push while full is impossible.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
  - IDLE: when count ≠ 0 and `m_busy` = 0, pop the head into the `addr`/`rw`/`data_wr` registers, set `en` = 1, clear the timer, and go to LAUNCH.
  - LAUNCH: hold `en` = 1 until `m_busy` = 1, then clear `en` and go to WAIT.
  - WAIT: `en` = 0. On `m_done` = 1:
    - Set `rsp_err` = {0, `m_nack`}.
    - Set `rsp_data` = `m_rdata` if `rw` = 1 and `m_nack` = 0, else 0.
    - Go to RESP.
  - RESP: `rsp_valid` = 1 with data and error held stable. On `rsp_ready` = 1, clear `rsp_valid` and go to IDLE.
- Timeout:
  - The timer counts in LAUNCH and WAIT.
  - When it reaches `TIMEOUT`: force `en` = 0, set `rsp_err` = 10 and `rsp_data` = 0, and go to RESP.
  - If `m_done` arrives in the same cycle the timer reaches `TIMEOUT`, `m_done` wins.
- `m_done` seen in LAUNCH (before `m_busy`) is treated exactly as in WAIT.
- `m_done` in IDLE or RESP is ignored.
- `addr`/`rw`/`data_wr` hold their last launched values until the next launch.
- Only one transaction is outstanding at a time. The next launch requires the response to have been consumed.

## Timing
- Reset values (all asynchronous):
  - `en` = 0, `addr` = 0, `rw` = 0, `data_wr` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 00.
  - `cmd_ready` = 1; count, pointers and timer = 0; FSM = IDLE.
- Reset mid-transaction drops `en` immediately, discards the FIFO contents and any pending response, and does not wait for the master.
- All outputs are registered except `cmd_ready`, which is decoded from the count register.
- Latency:
  - Command pushed at edge N into an empty FIFO with the FSM in IDLE and `m_busy` = 0 gives `en` = 1 after edge N+1.
  - `m_done` sampled at edge M gives `rsp_valid` = 1 after edge M.
  - `rsp_ready` sampled at edge R gives `rsp_valid` = 0 after R. The next launch with `en` = 1 follows at R+1 at the earliest.
- The timeout fires with `rsp_valid` high exactly `TIMEOUT` + 1 cycles after `en` rises.

## Test plan
- Write OK: push {0x0E, 0, 0x5A}. Expect `en` one cycle later with `addr` = 0x0E, `rw` = 0, `data_wr` = 0x5A. Model `m_busy` 3 cycles later and `m_done` (`m_nack` = 0) 20 cycles later. Expect `rsp_valid`, `rsp_err` = 00, `rsp_data` = 0x00.
- Read OK: push {0x0E, 1, x}. Model returns `m_rdata` = 0x2A with `m_nack` = 0. Expect `rsp_data` = 0x2A, `rsp_err` = 00.
- NACK: push to 0x11. Model returns `m_done` with `m_nack` = 1 and `m_rdata` = 0xFF. Expect `rsp_err` = 01, `rsp_data` = 0x00.
- Full/backpressure: hold `rsp_ready` = 0 and push 6 commands back-to-back.
  - Expect `cmd_ready` = 0 after 5 accepted (4 in the FIFO plus 1 launched).
  - The remaining command stalls.
  - Responses complete in push order with pointer wrap.
- Timeout: `TIMEOUT` = 16, model never asserts `m_busy`. Expect `en` = 0 and `rsp_valid` with `rsp_err` = 10, 17 cycles after `en` rose. Repeat with `m_done` coincident with timer expiry and expect `rsp_err` = 00.
- Reset mid-WAIT with 2 commands queued: expect `en` = 0 and `rsp_valid` = 0 immediately, `cmd_ready` = 1, and no launch after reset release until a new push.
